sram_write_monitor: RTL

Synthesizable, parametrised checker for writes issued to the external SRAM. It sits beside the SRAM controller in the project top level and snoops the write enable, address and write data. Each in-window write is compared against an expected-data store, and the monitor flags out-of-window and repeated writes. On request it sweeps a write bitmap and counts locations that were never written. It is a hardware version of the bench's write-checking and write-count logic, so a decode run can be checked on the board and shown on the seven-segment and LED outputs.

---
 rtl/sram_write_monitor.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_write_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sram_write_monitor
// Purpose  : Snoops SRAM writes, checks them against an expected-data store,
//            flags stray or repeated writes and counts unwritten locations.
// Revision : 1.0
// ============================================================================
module sram_write_monitor #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int REGION_BASE = 0,
    parameter int REGION_SIZE = 27648,
    parameter int CNT_W       = 16
) (
    input  logic                           Clock_50,
    input  logic                           Reset,
    input  logic                           Start,
    input  logic                           Finish,
    input  logic                           Mon_we_n,
    input  logic [ADDR_W-1:0]              Mon_address,
    input  logic [DATA_W-1:0]              Mon_write_data,
    output logic [$clog2(REGION_SIZE)-1:0] Exp_address,
    input  logic [DATA_W-1:0]              Exp_data,
    output logic                           Busy,
    output logic                           Done,
    output logic                           Error_flag,
    output logic [CNT_W-1:0]               Mismatch_count,
    output logic [CNT_W-1:0]               Out_of_region_count,
    output logic [CNT_W-1:0]               Multi_write_count,
    output logic [CNT_W-1:0]               Unwritten_count,
    output logic [ADDR_W-1:0]              First_err_address,
    output logic [DATA_W-1:0]              First_err_data,
    output logic [DATA_W-1:0]              First_err_expected
);

    localparam int OFF_W = $clog2(REGION_SIZE);
    localparam int IDX_W = $clog2(REGION_SIZE + 1);

    localparam logic [ADDR_W:0]   c_base = (ADDR_W+1)'(REGION_BASE);
    localparam logic [ADDR_W-1:0] c_size = ADDR_W'(REGION_SIZE);
    localparam logic [IDX_W-1:0]  c_last = IDX_W'(REGION_SIZE - 1);
    localparam logic [IDX_W-1:0]  c_end  = IDX_W'(REGION_SIZE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ARMED = 3'd2,
        S_DRAIN = 3'd3,
        S_SWEEP = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                drain_q, drain_d;
    logic                sw_vld_q, sw_vld_d;
    logic                s1_valid_q, s1_valid_d;
    logic [OFF_W-1:0]    s1_off_q, s1_off_d;
    logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
    logic [DATA_W-1:0]   s1_data_q, s1_data_d;
    logic                s1_fwd_q, s1_fwd_d;
    logic [CNT_W-1:0]    mm_cnt_q, mm_cnt_d;
    logic [CNT_W-1:0]    oor_cnt_q, oor_cnt_d;
    logic [CNT_W-1:0]    mw_cnt_q, mw_cnt_d;
    logic [CNT_W-1:0]    uw_cnt_q, uw_cnt_d;
    logic                cap_q, cap_d;
    logic [ADDR_W-1:0]   ferr_addr_q, ferr_addr_d;
    logic [DATA_W-1:0]   ferr_data_q, ferr_data_d;
    logic [DATA_W-1:0]   ferr_exp_q, ferr_exp_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [ADDR_W:0]     w_rel;
    logic                w_in_win;
    logic [OFF_W-1:0]    w_off;
    logic                w_armed;
    logic                w_acc;
    logic                w_oor;
    logic                w_mis;
    logic                w_multi;
    logic                mem_we;
    logic [OFF_W-1:0]    mem_waddr;
    logic                mem_wdata;
    logic [OFF_W-1:0]    mem_raddr;
    logic                bm_rd_q;
    logic                bitmap_mem [REGION_SIZE];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Borrow out of the subtraction means the address lies below the window.
    assign w_rel    = {1'b0, Mon_address} - c_base;
    assign w_in_win = !w_rel[ADDR_W] && (w_rel[ADDR_W-1:0] < c_size);
    assign w_off    = w_rel[OFF_W-1:0];
    assign w_armed  = (state_q == S_ARMED);
    assign w_acc    = w_armed && !Mon_we_n && w_in_win;
    assign w_oor    = w_armed && !Mon_we_n && !w_in_win;

    assign Exp_address = (w_acc && !Reset) ? w_off : '0;

    assign w_mis   = s1_valid_q && (s1_data_q != Exp_data);
    assign w_multi = s1_valid_q && (bm_rd_q || s1_fwd_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        drain_d     = drain_q;
        sw_vld_d    = 1'b0;
        s1_valid_d  = w_acc;
        s1_off_d    = w_off;
        s1_addr_d   = Mon_address;
        s1_data_d   = Mon_write_data;
        // The RAM returns the old bit when stage 1 writes the same entry.
        s1_fwd_d    = s1_valid_q && (s1_off_q == w_off);
        mm_cnt_d    = mm_cnt_q;
        oor_cnt_d   = oor_cnt_q;
        mw_cnt_d    = mw_cnt_q;
        uw_cnt_d    = uw_cnt_q;
        cap_d       = cap_q;
        ferr_addr_d = ferr_addr_q;
        ferr_data_d = ferr_data_q;
        ferr_exp_d  = ferr_exp_q;
        mem_we      = s1_valid_q;
        mem_waddr   = s1_off_q;
        mem_wdata   = 1'b1;
        mem_raddr   = w_armed ? w_off : idx_q[OFF_W-1:0];

        if (w_mis) begin
            mm_cnt_d = sat_inc(mm_cnt_q);
            if (!cap_q) begin
                cap_d       = 1'b1;
                ferr_addr_d = s1_addr_q;
                ferr_data_d = s1_data_q;
                ferr_exp_d  = Exp_data;
            end
        end
        if (w_multi) mw_cnt_d = sat_inc(mw_cnt_q);
        if (w_oor) oor_cnt_d = sat_inc(oor_cnt_q);
        if (sw_vld_q && !bm_rd_q) uw_cnt_d = sat_inc(uw_cnt_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d     = S_CLEAR;
                    idx_d       = '0;
                    mm_cnt_d    = '0;
                    oor_cnt_d   = '0;
                    mw_cnt_d    = '0;
                    uw_cnt_d    = '0;
                    cap_d       = 1'b0;
                    ferr_addr_d = '0;
                    ferr_data_d = '0;
                    ferr_exp_d  = '0;
                end
            end
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = idx_q[OFF_W-1:0];
                mem_wdata = 1'b0;
                if (idx_q == c_last) begin
                    state_d = S_ARMED;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_ARMED: begin
                if (Finish) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                    idx_d   = '0;
                end
            end
            S_DRAIN: begin
                if (!drain_q) begin
                    drain_d = 1'b1;
                end else begin
                    // The last bitmap write landed last cycle, so entry 0 can be read now.
                    state_d  = S_SWEEP;
                    sw_vld_d = 1'b1;
                    idx_d    = idx_q + IDX_W'(1);
                end
            end
            S_SWEEP: begin
                if (idx_q == c_end) begin
                    state_d = S_DONE;
                end else begin
                    sw_vld_d = 1'b1;
                    idx_d    = idx_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CLEAR) || (state_d == S_DRAIN) || (state_d == S_SWEEP);
        done_d = (state_d == S_DONE);
        err_d  = |{mm_cnt_d, oor_cnt_d, mw_cnt_d, uw_cnt_d};
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            drain_q     <= 1'b0;
            sw_vld_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_off_q    <= '0;
            s1_addr_q   <= '0;
            s1_data_q   <= '0;
            s1_fwd_q    <= 1'b0;
            mm_cnt_q    <= '0;
            oor_cnt_q   <= '0;
            mw_cnt_q    <= '0;
            uw_cnt_q    <= '0;
            cap_q       <= 1'b0;
            ferr_addr_q <= '0;
            ferr_data_q <= '0;
            ferr_exp_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            drain_q     <= drain_d;
            sw_vld_q    <= sw_vld_d;
            s1_valid_q  <= s1_valid_d;
            s1_off_q    <= s1_off_d;
            s1_addr_q   <= s1_addr_d;
            s1_data_q   <= s1_data_d;
            s1_fwd_q    <= s1_fwd_d;
            mm_cnt_q    <= mm_cnt_d;
            oor_cnt_q   <= oor_cnt_d;
            mw_cnt_q    <= mw_cnt_d;
            uw_cnt_q    <= uw_cnt_d;
            cap_q       <= cap_d;
            ferr_addr_q <= ferr_addr_d;
            ferr_data_q <= ferr_data_d;
            ferr_exp_q  <= ferr_exp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge Clock_50) begin
        if (mem_we) bitmap_mem[mem_waddr] <= mem_wdata;
        bm_rd_q <= bitmap_mem[mem_raddr];
    end

    assign Busy                = busy_q;
    assign Done                = done_q;
    assign Error_flag          = err_q;
    assign Mismatch_count      = mm_cnt_q;
    assign Out_of_region_count = oor_cnt_q;
    assign Multi_write_count   = mw_cnt_q;
    assign Unwritten_count     = uw_cnt_q;
    assign First_err_address   = ferr_addr_q;
    assign First_err_data      = ferr_data_q;
    assign First_err_expected  = ferr_exp_q;

endmodule
`default_nettype wire
